hazard_scoreboard: RTL and testbench

//  Central hazard unit for the 5-stage core: operand bypass select, load-use and

---
 rtl/hazard_scoreboard.sv | 162 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Central hazard unit for the 5-stage core. It selects operand bypasses for
//   the instruction in EXE, interlocks decode on load-use RAW hazards (with a
//   configurable load latency), and interlocks on RAW/WAW hazards against
//   variable-latency long ops (mul/div) that are tracked by a per-register
//   scoreboard. It also fans out branch flushes.
//
// Ports
//   clk, rst                   core clock, asynchronous active-high reset
//   dec_*                      decode-stage instruction fields
//   exe_a1, exe_a2             source registers of the instruction in EXE
//   mem_rd/mem_wr, wb_rd/wb_wr destination and write enable in MEM / WB
//   branch_taken               taken branch/jump resolved in MEM
//   long_done, long_done_rd    long unit write-back pulse and its register
//   fwd_rs1, fwd_rs2           bypass select: 0 reg file, 1 MEM, 2 WB
//   stall_fetch, stall_decode  hold fetch and decode
//   flush_decode/exe/mem       squash the named stage
//   long_outstanding           number of long ops in flight
module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int LOAD_LATENCY = 1,
  parameter int MAX_LONG_OPS = 2,
  localparam int RA_W        = $clog2(NUM_REGS),
  localparam int CW          = $clog2(MAX_LONG_OPS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  input  logic [RA_W-1:0] dec_rs1,
  input  logic [RA_W-1:0] dec_rs2,
  input  logic            dec_rs1_used,
  input  logic            dec_rs2_used,
  input  logic [RA_W-1:0] dec_rd,
  input  logic            dec_rd_wr,
  input  logic            dec_is_load,
  input  logic            dec_is_long,
  input  logic [RA_W-1:0] exe_a1,
  input  logic [RA_W-1:0] exe_a2,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_wr,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_wr,
  input  logic            branch_taken,
  input  logic            long_done,
  input  logic [RA_W-1:0] long_done_rd,
  output logic [1:0]      fwd_rs1,
  output logic [1:0]      fwd_rs2,
  output logic            stall_fetch,
  output logic            stall_decode,
  output logic            flush_decode,
  output logic            flush_exe,
  output logic            flush_mem,
  output logic [CW-1:0]   long_outstanding
);

  typedef enum logic [1:0] {
    FWD_REG_FILE  = 2'd0,
    FWD_MEMORY    = 2'd1,
    FWD_WRITEBACK = 2'd2
  } fwd_sel_e;

  // Load tracking pipe: entry 0 is the load currently in EXE. Only the entries
  // whose result is still unavailable are kept; once a load has moved past
  // entry LOAD_LATENCY-1 its result is reachable through the bypass network.
  logic [LOAD_LATENCY-1:0] ld_vld;
  logic [RA_W-1:0]         ld_rd [LOAD_LATENCY];

  logic [NUM_REGS-1:0]     sb_pend;     // bit 0 is never set
  logic                    exe_long_vld;
  logic [RA_W-1:0]         exe_long_rd;

  logic                    hz;
  logic                    issue;
  logic                    raw_ld;
  logic                    raw_lng;
  logic                    waw_lng;
  logic                    struct_hz;
  logic                    long_set;
  logic                    done_clr;
  logic                    squash_clr;

  function automatic fwd_sel_e fwd_pick(input logic [RA_W-1:0] src);
    if (mem_wr && mem_rd != '0 && mem_rd == src)     return FWD_MEMORY;
    else if (wb_wr && wb_rd != '0 && wb_rd == src)   return FWD_WRITEBACK;
    else                                             return FWD_REG_FILE;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    fwd_rs1 = fwd_pick(exe_a1);
    fwd_rs2 = fwd_pick(exe_a2);

    raw_ld = 1'b0;
    for (int i = 0; i < LOAD_LATENCY; i++) begin
      if (ld_vld[i] && ld_rd[i] != '0) begin
        if ((dec_rs1_used && dec_rs1 == ld_rd[i]) ||
            (dec_rs2_used && dec_rs2 == ld_rd[i]))
          raw_ld = 1'b1;
      end
    end

    // Uses the registered scoreboard, so a long_done this cycle on the same
    // register still stalls; the release is seen the following cycle.
    raw_lng   = (dec_rs1_used && sb_pend[dec_rs1]) ||
                (dec_rs2_used && sb_pend[dec_rs2]);
    waw_lng   = dec_rd_wr && sb_pend[dec_rd];
    struct_hz = dec_is_long && (long_outstanding == CW'(MAX_LONG_OPS)) && !long_done;

    hz           = dec_valid && (raw_ld || raw_lng || waw_lng || struct_hz);
    stall_fetch  = hz && !branch_taken;
    stall_decode = hz && !branch_taken;
    flush_decode = branch_taken;
    flush_mem    = branch_taken;
    flush_exe    = hz || branch_taken;

    issue    = dec_valid && !stall_decode && !branch_taken;
    long_set = issue && dec_is_long && dec_rd != '0;
    done_clr = long_done && sb_pend[long_done_rd];
    // A long op squashed in EXE by a branch gives back its slot, unless its
    // completion pulse already retired that same entry this cycle.
    squash_clr = branch_taken && exe_long_vld && sb_pend[exe_long_rd] &&
                 !(done_clr && long_done_rd == exe_long_rd);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_vld           <= '0;
      for (int i = 0; i < LOAD_LATENCY; i++) ld_rd[i] <= '0;
      sb_pend          <= '0;
      exe_long_vld     <= 1'b0;
      exe_long_rd      <= '0;
      long_outstanding <= '0;
    end else begin
      // issue is already low on a stall or branch, giving a bubble in entry 0.
      ld_vld[0] <= issue && dec_is_load && dec_rd_wr;
      ld_rd[0]  <= dec_rd;
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        ld_vld[i] <= ld_vld[i-1];
        ld_rd[i]  <= ld_rd[i-1];
      end

      begin
        logic [NUM_REGS-1:0] pend_n;
        pend_n = sb_pend;
        if (done_clr)              pend_n[long_done_rd] = 1'b0;
        if (branch_taken && exe_long_vld) pend_n[exe_long_rd] = 1'b0;
        if (long_set)              pend_n[dec_rd] = 1'b1;
        pend_n[0] = 1'b0;
        sb_pend <= pend_n;
      end

      exe_long_vld     <= long_set;
      exe_long_rd      <= dec_rd;
      long_outstanding <= long_outstanding + CW'(long_set)
                          - CW'(done_clr) - CW'(squash_clr);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed-vector bench for hazard_scoreboard. Two instances share all
//   inputs: dut (LOAD_LATENCY=1) and dut3 (LOAD_LATENCY=3).
module tb_hazard_scoreboard;

  localparam int RA_W = 5;
  localparam int CW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_wr;
  logic            dec_is_load, dec_is_long;
  logic [RA_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [RA_W-1:0] exe_a1, exe_a2, mem_rd, wb_rd, long_done_rd;
  logic            mem_wr, wb_wr, branch_taken, long_done;

  logic [1:0]      fwd_rs1, fwd_rs2, fwd_rs1_3, fwd_rs2_3;
  logic            stall_fetch, stall_decode, flush_decode, flush_exe, flush_mem;
  logic            stall_fetch_3, stall_decode_3, flush_decode_3, flush_exe_3, flush_mem_3;
  logic [CW-1:0]   long_outstanding, long_outstanding_3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LATENCY(1), .MAX_LONG_OPS(2)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr), .dec_is_load(dec_is_load),
    .dec_is_long(dec_is_long), .exe_a1(exe_a1), .exe_a2(exe_a2),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .branch_taken(branch_taken), .long_done(long_done), .long_done_rd(long_done_rd),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_decode(flush_decode), .flush_exe(flush_exe), .flush_mem(flush_mem),
    .long_outstanding(long_outstanding)
  );

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LATENCY(3), .MAX_LONG_OPS(2)) dut3 (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr), .dec_is_load(dec_is_load),
    .dec_is_long(dec_is_long), .exe_a1(exe_a1), .exe_a2(exe_a2),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .branch_taken(branch_taken), .long_done(long_done), .long_done_rd(long_done_rd),
    .fwd_rs1(fwd_rs1_3), .fwd_rs2(fwd_rs2_3),
    .stall_fetch(stall_fetch_3), .stall_decode(stall_decode_3),
    .flush_decode(flush_decode_3), .flush_exe(flush_exe_3), .flush_mem(flush_mem_3),
    .long_outstanding(long_outstanding_3)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    dec_rd = 0; dec_rd_wr = 0; dec_is_load = 0; dec_is_long = 0;
    exe_a1 = 0; exe_a2 = 0; mem_rd = 0; mem_wr = 0; wb_rd = 0; wb_wr = 0;
    branch_taken = 0; long_done = 0; long_done_rd = 0;
  endtask

  // Decode-stage instruction: rd (0 = no write), rs1/rs2 (0 = unused).
  task automatic dec(input int rd, input int rs1, input int rs2,
                     input bit is_load, input bit is_long);
    dec_valid    = 1;
    dec_rd       = RA_W'(rd);  dec_rd_wr    = (rd != 0);
    dec_rs1      = RA_W'(rs1); dec_rs1_used = (rs1 != 0);
    dec_rs2      = RA_W'(rs2); dec_rs2_used = (rs2 != 0);
    dec_is_load  = is_load;    dec_is_long  = is_long;
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks follow #1.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    #2;
    check("rst stall_fetch", stall_fetch, 0);
    check("rst flush_exe", flush_exe, 0);
    check("rst long_outstanding", long_outstanding, 0);
    check("rst fwd_rs1", fwd_rs1, 0);
    #10 rst = 0;
    step();

    // 1: lw x5 ; add x6,x5,x1 with LOAD_LATENCY=1
    dec(5, 0, 0, 1, 0); settle();
    check("t1 lw no stall", stall_decode, 0);
    step();
    dec(6, 5, 1, 0, 0); settle();
    check("t1 stall_fetch", stall_fetch, 1);
    check("t1 stall_decode", stall_decode, 1);
    check("t1 flush_exe", flush_exe, 1);
    step();
    dec(6, 5, 1, 0, 0); settle();
    check("t1 released", stall_decode, 0);
    step();
    exe_a1 = 5; exe_a2 = 1; wb_rd = 5; wb_wr = 1; settle();
    check("t1 fwd_rs1 wb", fwd_rs1, 2);
    check("t1 fwd_rs2 rf", fwd_rs2, 0);
    repeat (4) step();

    // 2: LOAD_LATENCY=3: lw x5 ; nop ; add x7,x5,x5
    dec(5, 0, 0, 1, 0); settle();
    step();
    dec(0, 0, 0, 0, 0); settle();
    check("t2 nop no stall", stall_decode_3, 0);
    step();
    dec(7, 5, 5, 0, 0); settle();
    check("t2 stall cyc1", stall_decode_3, 1);
    check("t2 ll1 no stall", stall_decode, 0);
    step();
    dec(7, 5, 5, 0, 0); settle();
    check("t2 stall cyc2", stall_decode_3, 1);
    check("t2 flush_exe cyc2", flush_exe_3, 1);
    step();
    dec(7, 5, 5, 0, 0); settle();
    check("t2 released", stall_decode_3, 0);
    step();
    exe_a1 = 5; exe_a2 = 5; settle();
    check("t2 fwd_rs1", fwd_rs1_3, 0);
    check("t2 fwd_rs2", fwd_rs2_3, 0);
    repeat (4) step();

    // 3: div x8 ; add x9,x8,x0 until long_done rd=8
    dec(8, 0, 0, 0, 1); settle();
    check("t3 div issue", stall_decode, 0);
    step();
    dec(9, 8, 0, 0, 0); settle();
    check("t3 raw stall", stall_decode, 1);
    check("t3 count 1", long_outstanding, 1);
    step();
    dec(9, 8, 0, 0, 0); long_done = 1; long_done_rd = 8; settle();
    check("t3 stall on done cycle", stall_decode, 1);
    step();
    dec(9, 8, 0, 0, 0); settle();
    check("t3 released", stall_decode, 0);
    check("t3 count 0", long_outstanding, 0);
    step();

    // 4: structural limit with MAX_LONG_OPS=2
    dec(8, 0, 0, 0, 1); settle();
    step();
    dec(9, 0, 0, 0, 1); settle();
    check("t4 2nd div no stall", stall_decode, 0);
    step();
    dec(10, 0, 0, 0, 1); settle();
    check("t4 count peak", long_outstanding, 2);
    check("t4 3rd div stall", stall_decode, 1);
    step();
    dec(10, 0, 0, 0, 1); settle();
    check("t4 still stall", stall_decode, 1);
    step();
    dec(10, 0, 0, 0, 1); long_done = 1; long_done_rd = 8; settle();
    check("t4 issue on done", stall_decode, 0);
    step();
    settle();
    check("t4 count after swap", long_outstanding, 2);
    long_done = 1; long_done_rd = 9;
    step();
    long_done = 1; long_done_rd = 10;
    step();
    settle();
    check("t4 drained", long_outstanding, 0);

    // 5: branch squashes div x8 in EXE
    dec(8, 0, 0, 0, 1); settle();
    step();
    branch_taken = 1; settle();
    check("t5 flush_decode", flush_decode, 1);
    check("t5 flush_exe", flush_exe, 1);
    check("t5 flush_mem", flush_mem, 1);
    check("t5 count before", long_outstanding, 1);
    step();
    settle();
    check("t5 count squashed", long_outstanding, 0);
    check("t5 flush_exe clear", flush_exe, 0);
    long_done = 1; long_done_rd = 8;
    step();
    dec(9, 8, 0, 0, 0); settle();
    check("t5 stray done ignored", long_outstanding, 0);
    check("t5 x8 not pending", stall_decode, 0);
    step();

    // 6: forwarding priority and x0
    exe_a1 = 3; exe_a2 = 3; mem_rd = 3; mem_wr = 1; wb_rd = 3; wb_wr = 1; settle();
    check("t6 mem wins rs1", fwd_rs1, 1);
    check("t6 mem wins rs2", fwd_rs2, 1);
    mem_rd = 0; wb_wr = 0; exe_a1 = 0; settle();
    check("t6 x0 no fwd", fwd_rs1, 0);
    step();

    // 6: async reset in the middle of a load-use stall with a long op pending
    dec(8, 0, 0, 0, 1); settle();
    step();
    dec(5, 0, 0, 1, 0); settle();
    step();
    dec(6, 5, 0, 0, 0); settle();
    check("t6 pre-rst stall", stall_decode, 1);
    check("t6 pre-rst count", long_outstanding, 1);
    #2 rst = 1;
    #1;
    check("t6 rst stall_fetch", stall_fetch, 0);
    check("t6 rst stall_decode", stall_decode, 0);
    check("t6 rst flush_exe", flush_exe, 0);
    check("t6 rst count", long_outstanding, 0);
    check("t6 rst fwd_rs1", fwd_rs1, 0);
    #3 rst = 0;
    step();
    dec(9, 8, 0, 0, 0); settle();
    check("t6 pending lost", stall_decode, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
